// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and special-case constants shared by the RV32M multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} mdu_state_e;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;
endpackage

// File: rtl/mdu_sign_fix.sv
// mdu_sign_fix: restores operand signs on the magnitude product/quotient/remainder and selects the result word
module mdu_sign_fix import mdu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  mdu_op_e           op,
  input  logic              sa,
  input  logic              sb,
  input  logic [2*XLEN-1:0] acc,
  output logic [XLEN-1:0]   res
);
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  // for divides acc holds {remainder, quotient}
  assign prod = (sa ^ sb) ? -acc : acc;
  assign quo  = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign res  = (op == MUL) ? prod[XLEN-1:0] : !op[2] ? prod[2*XLEN-1:XLEN] : !op[1] ? quo : rem;
endmodule

// File: rtl/mdu_e.sv
// mdu_e: iterative RV32M multiply/divide unit stalling the execute stage until done.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module mdu_e import mdu_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  mdu_state_e        state, state_n;
  mdu_op_e           op, op_in;
  logic              sa, sb, sa_in, sb_in, a_sig, b_sig;
  logic [XLEN-1:0]   ub, spec_res, fast_res, fix_res;
  logic [2*XLEN-1:0] acc, mul_step, div_step;
  logic [XLEN:0]     sum, sh, diff;
  logic [CNT_WIDTH-1:0] cnt;
  logic              div0, ovf, special, fast, last;
  assign op_in    = mdu_op_e'(funct3_i);
  assign a_sig    = op_in == MULH || op_in == MULHSU || op_in == DIV || op_in == REM;
  assign b_sig    = op_in == MULH || op_in == DIV || op_in == REM;
  assign sa_in    = a_sig & a_i[XLEN-1];
  assign sb_in    = b_sig & b_i[XLEN-1];
  assign div0     = funct3_i[2] && b_i == '0;
  assign ovf      = (op_in == DIV || op_in == REM) && a_i == INT_MIN && b_i == DIV0_QUOT;
  assign special  = div0 | ovf;
  assign spec_res = div0 ? (funct3_i[1] ? a_i : DIV0_QUOT) : (funct3_i[1] ? '0 : INT_MIN);
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fa, fb, fp;
  assign fa       = {{XLEN{sa_in}}, a_i};
  assign fb       = {{XLEN{sb_in}}, b_i};
  assign fp       = fa * fb;
  assign fast     = !funct3_i[2];
  assign fast_res = (op_in == MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif
  // shift-add multiply: multiplier in the low half, partial product in the high half
  assign sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, ub} : '0);
  assign mul_step = {sum, acc[XLEN-1:1]};
  // restoring divide: remainder in the high half, dividend shifting out into quotient bits
  assign sh       = acc[2*XLEN-1:XLEN-1];
  assign diff     = sh - {1'b0, ub};
  assign div_step = {diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]};
  assign last     = cnt == CNT_WIDTH'(XLEN - 1);
  mdu_sign_fix #(.XLEN(XLEN)) u_sign_fix (.op(op), .sa(sa), .sb(sb), .acc(acc), .res(fix_res));
  always_comb begin
    state_n = state == IDLE ? (start_i ? ((special | fast) ? DONE : CALC) : IDLE) :
              state == CALC ? (last ? FIX : CALC) : state == FIX ? DONE : IDLE;
    busy_o  = (state == IDLE && start_i) || state == CALC || state == FIX;
    done_o  = state == DONE;
  end
  always_ff @(posedge clk_i)
    state <= !rst_ni ? IDLE : state_n;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt      <= '0;
      acc      <= '0;
      ub       <= '0;
      op       <= MUL;
      sa       <= 1'b0;
      sb       <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          op  <= op_in;
          sa  <= sa_in;
          sb  <= sb_in;
          ub  <= sb_in ? -b_i : b_i;
          acc <= {{XLEN{1'b0}}, sa_in ? -a_i : a_i};
          cnt <= '0;
          if (special) result_o <= spec_res;
          else if (fast) result_o <= fast_res;
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          acc <= op[2] ? div_step : mul_step;
        end
        FIX: result_o <= fix_res;
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mdu_e.md
Name: mdu_e

Overview:
- RV32M multiply/divide unit in the execute stage.
- Consumes the operands and funct3 that the decode-to-execute register presents in execute. Iterates over multiple cycles. Holds the pipeline through a stall request to the hazard unit.
- Returns a 32-bit result that the execute result mux forwards to the execute-to-memory register.

Parameters:
- XLEN, 32, operand and result width.
- CNT_WIDTH, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  reset; synchronous, active-low.
- start_i  input  1  the instruction in execute is an M-extension op. Held high by the stalled pipeline.
- funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a_i  input  XLEN  rs1 operand, already forwarded.
- b_i  input  XLEN  rs2 operand, already forwarded.
- busy_o  output  1  stall request to the hazard unit; freezes fetch, decode and the execute register.
- done_o  output  1  one-cycle pulse: result_o is valid and the pipeline may advance.
- result_o  output  XLEN  operation result.

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset (rst_ni low at a clock edge):
  - State goes to IDLE; counter, accumulators and result_o go to 0; done_o goes to 0.
  - busy_o is 0 while in IDLE with start_i low.
  - Reset mid-operation aborts the op. No done pulse is generated.
- busy_o = (IDLE & start_i) | CALC | FIX. It is combinational, so the stall asserts in the same cycle the op reaches execute.
- IDLE with start_i high:
  - Latch funct3 and operand signs; take absolute values per op signedness (MULHSU: a signed, b unsigned).
  - Clear the counter, then go to CALC.
- IDLE special cases skip CALC and go straight to DONE with the result written:
  - DIV/DIVU by zero: quotient 0xFFFFFFFF; REM/REMU = a_i.
  - DIV of 0x80000000 by 0xFFFFFFFF: quotient 0x80000000, REM 0.
- CALC, exactly XLEN cycles:
  - Multiply: shift-add into a 2*XLEN product register.
  - Divide: restoring step, one quotient bit per cycle; XLEN-bit remainder.
  - Counter reaching XLEN-1 moves to FIX.
- FIX, one cycle:
  - Two's-complement negate the product when the operand signs differ (signed variants).
  - Quotient is negated when the signs differ; remainder takes the sign of the dividend.
  - Select low/high product word or quotient/remainder into result_o. Go to DONE.
- DONE, one cycle:
  - done_o = 1 and busy_o = 0, so the pipeline advances at this edge. Then go unconditionally to IDLE.
  - start_i still high in DONE is ignored; no restart.
  - start_i high in the following IDLE cycle is a new, back-to-back op.
- Latency: start accepted at cycle 0, CALC cycles 1..32, FIX cycle 33, DONE cycle 34. Special cases finish in DONE at cycle 1.
- result_o holds its value until the next FIX/special-case write.
- Operand inputs are not sampled after IDLE, so forwarding changes during the stall are harmless.

Optional Feature:
- Macro MDU_FAST_MUL_EN.
- Defined: MUL* ops compute a 2*XLEN combinational product in IDLE, register it, and go to DONE. Latency is 1 cycle; CALC and FIX are used only by divides.
- Undefined: all ops use the iterative CALC/FIX path; no wide multiplier is inferred.
- Divide behaviour is identical in both builds.

Decomposition:
- Package mdu_pkg holds:
  - mdu_op_e enum of the eight funct3 codes.
  - mdu_state_e enum {IDLE, CALC, FIX, DONE}.
  - Constants DIV0_QUOT = 0xFFFFFFFF and INT_MIN = 0x80000000.
- Sub-module mdu_sign_fix: combinational negate/select of the product, quotient and remainder given the op and the two operand signs. It is instantiated once, feeding FIX.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3): busy_o high cycles 0..33, done_o at cycle 34, result 0xFFFFFFEB. With MDU_FAST_MUL_EN, done at cycle 1.
- MULH 0x80000000×0x80000000 gives 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 gives 0xFFFFFFFF.
- DIVU 100/7 gives 14; REMU gives 2. DIV 0xFFFFFF9C (-100)/7 gives 0xFFFFFFF2; REM gives 0xFFFFFFFE. Done at cycle 34.
- DIV 0x14/0 gives 0xFFFFFFFF; REM 0x14/0 gives 0x14. DIV 0x80000000/0xFFFFFFFF gives 0x80000000, REM 0. All done at cycle 1.
- rst_ni low at cycle 10 of a DIV: next cycle busy_o=0, done_o=0, result_o=0. The following start runs the full 34 cycles.
- Back-to-back DIVU then MUL, start_i held high throughout: exactly two done_o pulses at cycles 34 and 69, with correct results each.
